// File: rtl/cpu_pkg.sv
// Shared types and constants for the single-cycle MIPS fetch path.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALTED,
    ST_FAULT
  } run_state_e;

  // Control-flow selects decoded from the current instruction.
  typedef struct packed {
    logic jr;
    logic jump;
    logic branch;
    logic zero;
  } pc_sel_t;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC selection (jr > j > taken beq > sequential) and jr
// target alignment check.
module pc_target_calc
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] pc_plus4_i,
  input  logic [XLEN-1:0] imm_ext_i,
  input  logic [25:0]     jtarget_i,
  input  logic [XLEN-1:0] rs_data_i,
  input  pc_sel_t         sel_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] branch_tgt;
  logic [XLEN-1:0] jump_tgt;

  // Word offset; the top two immediate bits shift out and the sum wraps freely.
  assign branch_tgt = pc_plus4_i + (imm_ext_i << 2);
  assign jump_tgt   = {pc_plus4_i[XLEN-1:28], jtarget_i, 2'b00};

  // NOTE: combinational outputs get a default before any branch so no path
  // leaves them unassigned, which would otherwise infer a latch.
  always_comb begin
    next_pc_o = pc_plus4_i;
    if (sel_i.jr) begin
      next_pc_o = rs_data_i;
    end else if (sel_i.jump) begin
      next_pc_o = jump_tgt;
    end else if (sel_i.branch && sel_i.zero) begin
      next_pc_o = branch_tgt;
    end
  end

  assign misalign_o = sel_i.jr && (rs_data_i[1:0] != 2'b00);

endmodule

// File: rtl/pc_next_unit.sv
// Program counter, run-control FSM and saturating retired-instruction counter
// for the single-cycle MIPS datapath.
module pc_next_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt,
  input  logic             stall,
  input  logic             branch,
  input  logic             zero,
  input  logic             jump,
  input  logic             jr,
  input  logic [XLEN-1:0]  imm_ext,
  input  logic [25:0]      jtarget,
  input  logic [XLEN-1:0]  rs_data,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             running,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  run_state_e       state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  pc_sel_t         sel;
  logic [XLEN-1:0] next_pc;
  logic            misalign;

  assign sel = '{jr: jr, jump: jump, branch: branch, zero: zero};

  assign pc_plus4 = pc_q + PC_INC;

  pc_target_calc u_target (
    .pc_plus4_i (pc_plus4),
    .imm_ext_i  (imm_ext),
    .jtarget_i  (jtarget),
    .rs_data_i  (rs_data),
    .sel_i      (sel),
    .next_pc_o  (next_pc),
    .misalign_o (misalign)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        // Entering RUN does not advance the PC on that edge.
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (halt) begin
          state_d = ST_HALTED;
        end else if (stall) begin
          state_d = ST_RUN;
        end else if (misalign) begin
          state_d = ST_FAULT;
        end else begin
          pc_d = next_pc;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign running     = (state_q == ST_RUN);
  assign fault       = (state_q == ST_FAULT);
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed vector table, hand-written
// reset/saturation sequences and randomized traffic against a behavioural model.
module tb_pc_next_unit;

  localparam int          CNT_W   = 6;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  // Control bits packed as {start, halt, stall, branch, zero, jump, jr}.
  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_START = 7'b1000000;
  localparam logic [6:0] C_HALT  = 7'b0100000;
  localparam logic [6:0] C_STALL = 7'b0010000;
  localparam logic [6:0] C_BR    = 7'b0001000;
  localparam logic [6:0] C_ZERO  = 7'b0000100;
  localparam logic [6:0] C_JUMP  = 7'b0000010;
  localparam logic [6:0] C_JR    = 7'b0000001;

  logic             clk, rst;
  logic             start, halt, stall, branch, zero, jump, jr;
  logic [31:0]      imm_ext, rs_data;
  logic [25:0]      jtarget;
  logic [31:0]      pc, pc_plus4;
  logic             running, fault;
  logic [CNT_W-1:0] instr_count;

  pc_next_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt        (halt),
    .stall       (stall),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .jr          (jr),
    .imm_ext     (imm_ext),
    .jtarget     (jtarget),
    .rs_data     (rs_data),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .running     (running),
    .fault       (fault),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] imm;
    logic [25:0] jt;
    logic [31:0] rs;
    logic [31:0] e_pc;
    int          e_cnt;
    logic        e_run;
    logic        e_fault;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [6:0] ctl, input logic [31:0] imm,
                              input logic [25:0] jt, input logic [31:0] rs,
                              input logic [31:0] e_pc, input int e_cnt,
                              input logic e_run, input logic e_fault);
    vec_t v;
    v.ctl = ctl; v.imm = imm; v.jt = jt; v.rs = rs;
    v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_run = e_run; v.e_fault = e_fault;
    return v;
  endfunction

  task automatic drive(input logic [6:0] ctl, input logic [31:0] imm,
                       input logic [25:0] jt, input logic [31:0] rs);
    {start, halt, stall, branch, zero, jump, jr} = ctl;
    imm_ext = imm;
    jtarget = jt;
    rs_data = rs;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"},      pc,                 32'h0);
    check({tag, "_cnt"},     32'(instr_count),   32'h0);
    check({tag, "_running"}, 32'(running),       32'h0);
    check({tag, "_fault"},   32'(fault),         32'h0);
  endtask

  // Reference model: run/fault flags plus plain 32-bit arithmetic on the PC.
  logic [31:0] m_pc;
  int unsigned m_cnt;
  bit          m_run, m_fault;

  function automatic logic [31:0] model_target(input logic [31:0] cur_pc);
    logic [31:0] seq;
    seq = cur_pc + 32'd4;
    if (jr)                return rs_data;
    if (jump)              return (seq & 32'hF000_0000) | (32'(jtarget) * 32'd4);
    if (branch && zero)    return seq + imm_ext * 32'd4;
    return seq;
  endfunction

  task automatic model_edge();
    if (m_fault) begin
      // only reset leaves fault
    end else if (!m_run) begin
      if (start) m_run = 1'b1;
    end else if (halt) begin
      m_run = 1'b0;
    end else if (stall) begin
      // hold
    end else if (jr && (rs_data % 4 != 0)) begin
      m_run   = 1'b0;
      m_fault = 1'b1;
    end else begin
      m_pc = model_target(m_pc);
      if (m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_cnt = 0; m_run = 1'b0; m_fault = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_pc"},      pc,               m_pc);
    check({tag, "_pc_plus4"},pc_plus4,         m_pc + 32'd4);
    check({tag, "_cnt"},     32'(instr_count), 32'(m_cnt));
    check({tag, "_running"}, 32'(running),     32'(m_run));
    check({tag, "_fault"},   32'(fault),       32'(m_fault));
  endtask

  initial begin
    rst = 1'b1;
    drive(C_NONE, 32'h0, 26'h0, 32'h0);

    // Directed sequence from reset; each entry is one clock edge.
    vt.push_back(mk(C_JUMP,                32'h0,        26'h5,  32'h0,        32'h0000_0000, 0,  0, 0));
    vt.push_back(mk(C_START | C_JR,        32'h0,        26'h0,  32'h40,       32'h0000_0000, 0,  1, 0));
    vt.push_back(mk(C_NONE,                32'h0,        26'h0,  32'h0,        32'h0000_0004, 1,  1, 0));
    vt.push_back(mk(C_NONE,                32'h0,        26'h0,  32'h0,        32'h0000_0008, 2,  1, 0));
    vt.push_back(mk(C_NONE,                32'h0,        26'h0,  32'h0,        32'h0000_000C, 3,  1, 0));
    vt.push_back(mk(C_JR,                  32'h0,        26'h0,  32'h100,      32'h0000_0100, 4,  1, 0));
    vt.push_back(mk(C_BR | C_ZERO,         32'h1C8,      26'h0,  32'h0,        32'h0000_0824, 5,  1, 0));
    vt.push_back(mk(C_JR,                  32'h0,        26'h0,  32'h100,      32'h0000_0100, 6,  1, 0));
    vt.push_back(mk(C_BR,                  32'h1C8,      26'h0,  32'h0,        32'h0000_0104, 7,  1, 0));
    vt.push_back(mk(C_JR,                  32'h0,        26'h0,  32'h40,       32'h0000_0040, 8,  1, 0));
    vt.push_back(mk(C_BR | C_ZERO,         32'hFFFFFF78, 26'h0,  32'h0,        32'hFFFF_FE24, 9,  1, 0));
    vt.push_back(mk(C_JR,                  32'h0,        26'h0,  32'h10,       32'h0000_0010, 10, 1, 0));
    vt.push_back(mk(C_BR | C_ZERO,         32'hFFFFFFFF, 26'h0,  32'h0,        32'h0000_0010, 11, 1, 0));
    vt.push_back(mk(C_JR,                  32'h0,        26'h0,  32'h9000_0000,32'h9000_0000, 12, 1, 0));
    vt.push_back(mk(C_JUMP,                32'h0,        26'h40, 32'h0,        32'h9000_0100, 13, 1, 0));
    vt.push_back(mk(C_JR | C_JUMP | C_BR | C_ZERO, 32'h8, 26'h3, 32'h200,      32'h0000_0200, 14, 1, 0));
    vt.push_back(mk(C_JUMP | C_BR | C_ZERO,32'h4,        26'h1,  32'h0,        32'h0000_0004, 15, 1, 0));
    vt.push_back(mk(C_STALL,               32'h0,        26'h0,  32'h0,        32'h0000_0004, 15, 1, 0));
    vt.push_back(mk(C_STALL | C_JR,        32'h0,        26'h0,  32'h1002,     32'h0000_0004, 15, 1, 0));
    vt.push_back(mk(C_HALT | C_JR,         32'h0,        26'h0,  32'h1002,     32'h0000_0004, 15, 0, 0));
    vt.push_back(mk(C_JUMP,                32'h0,        26'h7,  32'h0,        32'h0000_0004, 15, 0, 0));
    vt.push_back(mk(C_START,               32'h0,        26'h0,  32'h0,        32'h0000_0004, 15, 1, 0));
    vt.push_back(mk(C_NONE,                32'h0,        26'h0,  32'h0,        32'h0000_0008, 16, 1, 0));
    vt.push_back(mk(C_START | C_JR,        32'h0,        26'h0,  32'h1002,     32'h0000_0008, 16, 0, 1));
    vt.push_back(mk(C_START,               32'h0,        26'h0,  32'h0,        32'h0000_0008, 16, 0, 1));
    vt.push_back(mk(C_JUMP,                32'h0,        26'h9,  32'h0,        32'h0000_0008, 16, 0, 1));

    #12;
    check_reset_outputs("reset");
    check("reset_pc_plus4", pc_plus4, 32'h4);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].ctl, vt[i].imm, vt[i].jt, vt[i].rs);
      step();
      check($sformatf("vec%0d_pc", i),       pc,               vt[i].e_pc);
      check($sformatf("vec%0d_pc_plus4", i), pc_plus4,         vt[i].e_pc + 32'd4);
      check($sformatf("vec%0d_cnt", i),      32'(instr_count), 32'(vt[i].e_cnt));
      check($sformatf("vec%0d_running", i),  32'(running),     32'(vt[i].e_run));
      check($sformatf("vec%0d_fault", i),    32'(fault),       32'(vt[i].e_fault));
    end

    // Reset clears FAULT without a clock edge.
    drive(C_NONE, 32'h0, 26'h0, 32'h0);
    rst = 1'b1;
    #1;
    check_reset_outputs("fault_clear");
    rst = 1'b0;

    // Counter saturation: 70 unstalled instructions into a 6-bit counter.
    drive(C_START, 32'h0, 26'h0, 32'h0);
    step();
    drive(C_NONE, 32'h0, 26'h0, 32'h0);
    for (int i = 1; i <= 70; i++) begin
      step();
      if (i == 62) check("sat_cnt_62", 32'(instr_count), 32'd62);
      if (i == 63) check("sat_cnt_63", 32'(instr_count), 32'd63);
    end
    check("sat_cnt_held", 32'(instr_count), 32'd63);
    check("sat_pc",       pc,               32'd280);
    check("sat_running",  32'(running),     32'd1);

    // Asynchronous reset mid-RUN, checked between clock edges.
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    rst = 1'b0;

    // Randomized traffic against the model.
    model_reset();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        compare_model($sformatf("rnd%0d_rst", n));
        rst = 1'b0;
      end
      start   = ($urandom_range(0, 5) == 0);
      halt    = ($urandom_range(0, 15) == 0);
      stall   = ($urandom_range(0, 5) == 0);
      branch  = ($urandom_range(0, 2) == 0);
      zero    = $urandom_range(0, 1) == 1;
      jump    = ($urandom_range(0, 5) == 0);
      jr      = ($urandom_range(0, 5) == 0);
      imm_ext = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 255)) - 128);
      jtarget = 26'($urandom);
      rs_data = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) rs_data = rs_data | 32'($urandom_range(1, 3));
      model_edge();
      step();
      compare_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Program-counter register and next-PC selection for the single-cycle MIPS datapath.
- Consumes the 32-bit sign-extended immediate for branch targets, the 26-bit jump field, and the rs register value for jr.
- Produces the fetch address for instruction memory.
- Adds a small run-control FSM (idle/run/halt/fault) and a retired-instruction counter for bring-up and test.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  leave IDLE or HALTED and enter RUN
- halt  in  1  stop fetching; enter HALTED
- stall  in  1  hold PC and counter for this cycle
- branch  in  1  current instruction is a conditional branch (beq)
- zero  in  1  ALU zero flag; branch taken when branch & zero
- jump  in  1  current instruction is j
- jr  in  1  current instruction is jr
- imm_ext  in  32  sign-extended 16-bit immediate
- jtarget  in  26  instr[25:0]
- rs_data  in  32  register-file rs read value
- pc  out  32  current fetch address (registered)
- pc_plus4  out  32  pc + 4 (combinational)
- running  out  1  high while in RUN
- fault  out  1  high in FAULT
- instr_count  out  CNT_W  instructions retired

Behaviour:
- Reset (asynchronous, active-high): pc=RESET_PC, state=IDLE, instr_count=0, running=0, fault=0.
- pc_plus4 = pc + 32'd4, modulo 2^32.
- States:
  - IDLE: pc held. start=1 -> RUN at the next edge. No PC update on that edge.
  - RUN: running=1. Each edge evaluates in this priority: halt > stall > next-PC update.
    - halt=1 -> HALTED; pc and count held.
    - else stall=1 -> pc and count held.
    - else pc <= next_pc; instr_count++.
  - HALTED: pc held, running=0. start=1 -> RUN at the next edge.
  - FAULT: pc held, fault=1, running=0. Only rst exits this state.
- start in RUN or FAULT is ignored.
- next_pc priority, highest first:
  - jr: rs_data.
  - jump: {pc_plus4[31:28], jtarget, 2'b00}.
  - branch & zero: pc_plus4 + {imm_ext[29:0], 2'b00}. Addition is modulo 2^32, wrap-around allowed and not a fault.
  - otherwise: pc_plus4.
  - Simultaneous selects resolve by this priority without error.
- Misaligned jr:
  - In RUN with halt=0, stall=0, jr=1 and rs_data[1:0]!=0: state -> FAULT, pc not updated, count not incremented.
  - halt or stall in the same cycle suppresses the fault check.
- instr_count saturates at all-ones and does not wrap.
- Latency: next_pc is visible on pc one cycle after the inputs are sampled. There is no other pipelining.
- Reset asserted mid-RUN: outputs return to reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum ST_IDLE, ST_RUN, ST_HALTED, ST_FAULT
  - constant PC_INC = 4
  - constant XLEN = 32
- One natural sub-module: pc_target_calc, purely combinational. Inputs are pc_plus4, imm_ext, jtarget, rs_data and the selects. Outputs are next_pc and a misalign flag.
- The FSM, pc register and counter stay in the top module.

Test Plan:
- Reset then start, RESET_PC=0, no selects, 3 unstalled cycles -> pc=0x0C, instr_count=3.
- pc=0x100, branch=1, zero=1, imm_ext=0x000001C8 (456) -> pc=0x824. Repeat with zero=0 -> pc=0x104.
- Backward branch wrap: pc=0x40, imm_ext=0xFFFFFF78 (-136), taken -> pc=0xFFFFFE24, fault=0.
- Self-loop: pc=0x10, imm_ext=0xFFFFFFFF, taken -> pc=0x10.
- Jump: pc=0x9000_0000, jump=1, jtarget=0x40 -> pc=0x9000_0100.
- jr and run control:
  - jr=1, rs_data=0x1002 -> FAULT, pc unchanged, fault=1.
  - start then has no effect; rst clears the fault.
  - stall=1 for 2 cycles -> pc and count frozen.
  - halt -> HALTED; start -> RUN; pc resumes from the held value.
